// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, ALU control codes used by the
// ALU control decoder and the execute stage, and the execute-stage FSM states.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_ADD = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd5;
    localparam logic [3:0] ALU_MUL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/ex_alu_unit_if.sv
// Operation/result bundle between the ID/EX register, the hazard unit and the
// execute-stage ALU. The master side presents operations; the ALU is the slave.
interface ex_alu_unit_if;

    // Handshake: an op is taken when valid_i=1, flush_i=0 and stall_o=0 at a
    // rising edge, except that a MUL is latched in the cycle it first appears
    // (stall_o=1) and the master must hold it until stall_o drops.
    // valid_o is a one-cycle pulse qualifying result_o/zero_o.
    logic                       valid_i;
    logic                       flush_i;
    logic [3:0]                 ALUCtrl_i;
    logic [riscv_pkg::XLEN-1:0] data1_i;
    logic [riscv_pkg::XLEN-1:0] data2_i;
    logic                       stall_o;
    logic                       valid_o;
    logic [riscv_pkg::XLEN-1:0] result_o;
    logic                       zero_o;

    modport master (
        output valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
        input  stall_o, valid_o, result_o, zero_o
    );

    modport slave (
        input  valid_i, flush_i, ALUCtrl_i, data1_i, data2_i,
        output stall_o, valid_o, result_o, zero_o
    );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// done_o marks the final step; product_o is the accumulator after that step.
module mul_iter
    import riscv_pkg::*;
#(
    parameter int MUL_BITS = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int STEPS = XLEN / MUL_BITS;

    logic [XLEN-1:0] a_sh;
    logic [XLEN-1:0] b_sh;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [XLEN-1:0] partial;
    logic [5:0]      cnt;

    // a_sh carries the multiplicand pre-shifted to the weight of b_sh[0].
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (b_sh[i]) begin
                partial = partial + (a_sh << i);
            end
        end
        acc_next = acc + partial;
    end

    assign product_o = acc_next;
    assign done_o    = (cnt == 6'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (abort_i) begin
            cnt <= '0;
        end else if (start_i) begin
            a_sh <= a_i;
            b_sh <= b_i;
            acc  <= '0;
            cnt  <= 6'(STEPS);
        end else if (cnt != 6'd0) begin
            acc  <= acc_next;
            a_sh <= a_sh << MUL_BITS;
            b_sh <= b_sh >> MUL_BITS;
            cnt  <= cnt - 6'd1;
        end
    end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/shift/add ops with a registered result,
// plus an iterative multiply that stalls the ID/EX register until it completes.
module ex_alu_unit
    import riscv_pkg::*;
#(
    parameter int MUL_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ex_alu_unit_if.slave        bus,
    output alu_state_t          state_o
);

    alu_state_t      state;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mul_product;
    logic            mul_done;
    logic            mul_start;
    logic            mul_abort;
    logic            stall;
    logic            valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl_i)
            ALU_AND: alu_res = bus.data1_i & bus.data2_i;
            ALU_XOR: alu_res = bus.data1_i ^ bus.data2_i;
            ALU_SLL: alu_res = bus.data1_i << bus.data2_i[4:0];
            ALU_ADD: alu_res = bus.data1_i + bus.data2_i;
            ALU_SUB: alu_res = bus.data1_i - bus.data2_i;
            ALU_SRA: alu_res = XLEN'($signed(bus.data1_i) >>> bus.data2_i[4:0]);
            ALU_OR:  alu_res = bus.data1_i | bus.data2_i;
            default: alu_res = '0;
        endcase
    end

    assign mul_start = (state == IDLE) && bus.valid_i && !bus.flush_i &&
                       (bus.ALUCtrl_i == ALU_MUL);
    assign mul_abort = (state == MUL) && bus.flush_i;

    mul_iter #(.MUL_BITS(MUL_BITS)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .abort_i   (mul_abort),
        .a_i       (bus.data1_i),
        .b_i       (bus.data2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Stall is released on the final multiply step so the next op lines up
    // with the cycle the product becomes visible.
    always_comb begin
        stall = 1'b0;
        if (!rst_i && !bus.flush_i) begin
            case (state)
                IDLE:    stall = mul_start;
                MUL:     stall = !mul_done;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i && !bus.flush_i) begin
                        if (bus.ALUCtrl_i == ALU_MUL) begin
                            state <= MUL;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            valid_q  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else if (mul_done) begin
                        result_q <= mul_product;
                        zero_q   <= (mul_product == '0);
                        valid_q  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_o  = stall;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign state_o      = state;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit (MUL_BITS=2): reset, single-cycle ops,
// iterative multiply timing, reset/flush during multiply, undefined codes.
module tb_ex_alu_unit;
  import riscv_pkg::*;

  localparam int STEPS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  alu_state_t state;
  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  logic        exp_z[$];

  always #5 clk = ~clk;

  ex_alu_unit_if bus();

  ex_alu_unit #(.MUL_BITS(2)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] code,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_i   = v;
    bus.ALUCtrl_i = code;
    bus.data1_i   = a;
    bus.data2_i   = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush_i = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid_o); else passed++;
    checks++; if (bus.result_o !== 32'd0) $display("FAIL reset_result got %h want 0", bus.result_o); else passed++;
    checks++; if (bus.zero_o !== 1'b0) $display("FAIL reset_zero got %b want 0", bus.zero_o); else passed++;
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stall_o); else passed++;
    checks++; if (state !== IDLE) $display("FAIL reset_state got %0d want IDLE", state); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_logic();
    logic [3:0]  codes[3] = '{ALU_AND, ALU_XOR, ALU_OR};
    logic [31:0] exps[3]  = '{32'hF000_F000, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, codes[i], 32'hF0F0_F0F0, 32'hFF00_FF00);
      tick();
      checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== exps[i])
        $display("FAIL logic_op%0d got v=%b r=%h want v=1 r=%h", i, bus.valid_o, bus.result_o, exps[i]);
      else passed++;
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  codes[4] = '{ALU_ADD, ALU_SUB, ALU_SRA, ALU_SLL};
    logic [31:0] as[4]    = '{32'd7, 32'd5, 32'h8000_0000, 32'd1};
    logic [31:0] bs[4]    = '{32'd5, 32'd5, 32'd4, 32'd31};
    logic [31:0] e;
    logic        ez;
    exp_q.push_back(32'd12);        exp_z.push_back(1'b0);
    exp_q.push_back(32'd0);         exp_z.push_back(1'b1);
    exp_q.push_back(32'hF800_0000); exp_z.push_back(1'b0);
    exp_q.push_back(32'h8000_0000); exp_z.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, codes[i], as[i], bs[i]);
      checks++; if (bus.stall_o !== 1'b0) $display("FAIL b2b_stall%0d got %b want 0", i, bus.stall_o); else passed++;
      tick();
      e  = exp_q.pop_front();
      ez = exp_z.pop_front();
      checks++; if (bus.valid_o !== 1'b1) $display("FAIL b2b_valid%0d got %b want 1", i, bus.valid_o); else passed++;
      checks++; if (bus.result_o !== e) $display("FAIL b2b_result%0d got %h want %h", i, bus.result_o, e); else passed++;
      checks++; if (bus.zero_o !== ez) $display("FAIL b2b_zero%0d got %b want %b", i, bus.zero_o, ez); else passed++;
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL b2b_pulse_end got %b want 0", bus.valid_o); else passed++;
  endtask

  task automatic test_mul();
    int hi = 0;
    logic early = 1'b0;
    drive(1'b1, ALU_MUL, 32'hFFFF_FFFF, 32'd3);
    for (int i = 0; i < STEPS; i++) begin
      if (bus.stall_o === 1'b1) hi++;
      if (bus.valid_o !== 1'b0) early = 1'b1;
      tick();
    end
    checks++; if (hi != STEPS) $display("FAIL mul_stall_cycles got %0d want %0d", hi, STEPS); else passed++;
    checks++; if (early !== 1'b0) $display("FAIL mul_early_valid got %b want 0", early); else passed++;
    checks++; if (bus.stall_o !== 1'b0 || bus.valid_o !== 1'b0)
      $display("FAIL mul_last_step got stall=%b valid=%b want 0/0", bus.stall_o, bus.valid_o);
    else passed++;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checks++; if (bus.valid_o !== 1'b1) $display("FAIL mul_valid got %b want 1", bus.valid_o); else passed++;
    checks++; if (bus.result_o !== 32'hFFFF_FFFD) $display("FAIL mul_result got %h want fffffffd", bus.result_o); else passed++;
    checks++; if (bus.zero_o !== 1'b0) $display("FAIL mul_zero got %b want 0", bus.zero_o); else passed++;
    tick();
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL mul_pulse_end got %b want 0", bus.valid_o); else passed++;
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, ALU_MUL, 32'd5, 32'd7);
    repeat (5) tick();
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL rstmul_stall_in_reset got %b want 0", bus.stall_o); else passed++;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (state !== IDLE) $display("FAIL rstmul_state got %0d want IDLE", state); else passed++;
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL rstmul_valid got %b want 0", bus.valid_o); else passed++;
    checks++; if (bus.result_o !== 32'd0) $display("FAIL rstmul_result got %h want 0", bus.result_o); else passed++;
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL rstmul_stall got %b want 0", bus.stall_o); else passed++;
    drive(1'b1, ALU_ADD, 32'd1, 32'd1);
    tick();
    checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd2)
      $display("FAIL rstmul_add got v=%b r=%h want v=1 r=2", bus.valid_o, bus.result_o);
    else passed++;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_mul_overflow();
    int n = 0;
    drive(1'b1, ALU_MUL, 32'h0001_0000, 32'h0001_0000);
    while (bus.stall_o === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != STEPS) $display("FAIL mulov_stall_cycles got %0d want %0d", n, STEPS); else passed++;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd0 || bus.zero_o !== 1'b1)
      $display("FAIL mulov_result got v=%b r=%h z=%b want v=1 r=0 z=1", bus.valid_o, bus.result_o, bus.zero_o);
    else passed++;
    tick();
  endtask

  task automatic test_flush_mul();
    int pulses = 0;
    drive(1'b1, ALU_ADD, 32'd3, 32'd4);
    tick();
    checks++; if (bus.result_o !== 32'd7) $display("FAIL flush_pre_add got %h want 7", bus.result_o); else passed++;
    drive(1'b1, ALU_MUL, 32'd9, 32'd9);
    repeat (4) tick();
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL flush_stall got %b want 0", bus.stall_o); else passed++;
    tick();
    bus.flush_i = 1'b0;
    drive(1'b1, ALU_ADD, 32'd10, 32'd20);
    checks++; if (state !== IDLE) $display("FAIL flush_state got %0d want IDLE", state); else passed++;
    checks++; if (bus.valid_o !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.valid_o); else passed++;
    checks++; if (bus.result_o !== 32'd7) $display("FAIL flush_result_kept got %h want 7", bus.result_o); else passed++;
    checks++; if (bus.stall_o !== 1'b0) $display("FAIL flush_add_stall got %b want 0", bus.stall_o); else passed++;
    tick();
    checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd30)
      $display("FAIL flush_add got v=%b r=%h want v=1 r=1e", bus.valid_o, bus.result_o);
    else passed++;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.valid_o !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL flush_no_mul_pulse got %0d want 0", pulses); else passed++;
  endtask

  task automatic test_undefined();
    drive(1'b1, 4'd12, 32'hAAAA_AAAA, 32'h5555_5555);
    tick();
    checks++; if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd0 || bus.zero_o !== 1'b1)
      $display("FAIL undef_code got v=%b r=%h z=%b want v=1 r=0 z=1", bus.valid_o, bus.result_o, bus.zero_o);
    else passed++;
    bus.flush_i = 1'b1;
    drive(1'b1, ALU_ADD, 32'd1, 32'd2);
    tick();
    checks++; if (bus.valid_o !== 1'b0 || bus.result_o !== 32'd0)
      $display("FAIL flush_with_valid got v=%b r=%h want v=0 r=0", bus.valid_o, bus.result_o);
    else passed++;
    bus.flush_i = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    test_reset();
    test_logic();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    test_mul_overflow();
    test_flush_mul();
    test_undefined();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ex_alu_unit.md
# ex_alu_unit

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and the two forwarded operands. It computes a registered 32-bit result and zero flag. Single-cycle operations have a fixed latency of one cycle. Multiply runs on an iterative shift-add datapath and raises a stall toward the hazard unit until the product is ready. A pipeline flush can abort an in-flight multiply.

## Interface
Parameters:
- MUL_BITS, default 2: multiplier bits retired per cycle. Legal values are 1, 2, 4 and 8. STEPS = 32/MUL_BITS.

Ports:
- clk_i  in  1  clock. All state changes on its rising edge.
- rst_i  in  1  reset. Synchronous, active-high.
- valid_i  in  1  an operation is presented this cycle.
- flush_i  in  1  kill the current or pending operation.
- ALUCtrl_i  in  4  operation code: 1 AND, 2 XOR, 3 SLL, 4 ADD, 5 SUB, 6 MUL, 7 SRA, 8 OR.
- data1_i  in  32  operand A.
- data2_i  in  32  operand B. Bits [4:0] give the shift amount for SLL and SRA.
- stall_o  out  1  combinational. Tells the hazard unit to freeze the ID/EX register.
- valid_o  out  1  result_o and zero_o are valid this cycle.
- result_o  out  32  registered result.
- zero_o  out  1  registered; equals (result_o == 0). Used for beq.

## Operation
- FSM states: IDLE, MUL.
- Reset (rst_i=1): state←IDLE. valid_o, result_o, zero_o and the step counter all ←0. stall_o=0 while rst_i=1. Reset overrides every other input, including mid-multiply.
- IDLE, valid_i=1, flush_i=0, code≠6:
  - Compute the op and register it.
  - valid_o=1 on the next cycle.
  - stall_o=0.
- IDLE, valid_i=1, flush_i=0, code=6:
  - Latch the operands, load the counter with STEPS, clear the accumulator, go to MUL.
  - stall_o=1 in this cycle.
  - valid_o=0 on the next cycle.
- MUL, each cycle:
  - Add data1·(next MUL_BITS multiplier bits), suitably shifted, into the accumulator and decrement the counter.
  - stall_o=1 unless this is the final step (counter==1).
  - On the final step: result_o←accumulator[31:0], zero_o updated, valid_o=1 next cycle, go to IDLE.
  - valid_i and operands are ignored in MUL; the operands are frozen upstream.
- Arithmetic and width rules:
  - ADD and SUB wrap modulo 2^32.
  - MUL returns the low 32 bits of the product. Signed and unsigned give identical low bits.
  - SLL is a logical left shift. SRA replicates data1_i[31].
  - Undefined codes (0, 9–15) return result 0 and zero_o=1, with valid_o still pulsing.
- valid_o is a single-cycle pulse. It drops to 0 on any cycle with no completing op.
- flush_i=1:
  - In IDLE: no op is accepted, stall_o=0, and valid_o=0 next cycle.
  - In MUL: abort, go to IDLE, stall_o=0 this cycle, valid_o=0 next cycle. result_o keeps its previous value.
  - flush_i with valid_i in the same cycle: flush wins.

## Timing
- Non-MUL op accepted at cycle T: valid_o at T+1. Back-to-back issue is allowed every cycle.
- MUL accepted at T: stall_o high for cycles T through T+STEPS−1 (STEPS cycles), and low at T+STEPS.
  - valid_o at T+STEPS+1 (T+17 for MUL_BITS=2).
  - The ID/EX register advances at the end of T+STEPS, so the next op can be accepted in IDLE at T+STEPS+1.
- No combinational path from the data inputs to result_o. stall_o depends only on state, counter, valid_i, ALUCtrl_i, flush_i and rst_i.

## Structure
- Shared package riscv_pkg holds:
  - ALU control code constants (ALU_AND=1 … ALU_OR=8), shared with the ALU control decoder.
  - The XLEN=32 constant.
  - The state enum for this FSM.
- Sub-module mul_iter holds the iterative multiplier: accumulator, shift registers, step counter, and start/abort/done ports. ex_alu_unit holds the FSM, the single-cycle ops, the result registers and the stall logic.

## Test plan
- Apply reset mid-MUL at cycle T+5. Next cycle: state IDLE, valid_o=0, result_o=0, stall_o=0. Then ADD 1+1 → valid_o next cycle, result 2.
- Issue back-to-back ADD 7+5, SUB 5−5, SRA 0x80000000>>>4, SLL 1<<31, one per cycle. Expect consecutive valid_o pulses with:
  - 12, zero 0
  - 0, zero 1
  - 0xF8000000
  - 0x80000000
- MUL 0xFFFFFFFF×3 with MUL_BITS=2:
  - stall_o high for exactly 16 cycles.
  - valid_o at T+17 with result 0xFFFFFFFD, zero_o=0.
  - No valid_o pulse in between.
- MUL 0x10000×0x10000: result 0 (overflow wraps), zero_o=1.
- flush_i at T+4 during a MUL: stall_o low that cycle, no valid_o for the MUL, result_o unchanged. An ADD at T+5 is accepted normally.
- Undefined code 12 with valid_i: valid_o next cycle, result 0, zero_o=1. flush_i together with valid_i (ADD): no valid_o.
